// File: rtl/fsm_trace_checker.sv
// fsm_trace_checker: passive monitor for a modulo-NSTATES counting FSM.
// Each enabled sample of y is classified as hold, advance or error.
// The first error freezes the checker and records its cause and context.
// Completed laps, that is (NSTATES-1)->0 steps, are counted up to a
// saturating limit of 255.
module fsm_trace_checker #(
    parameter int NSTATES = 9,   // legal encodings are 0..NSTATES-1, range 2..16
    parameter int TIMEOUT = 16   // repeat samples of one state tolerated before a stall
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] y,
    output logic       seen,
    output logic [7:0] wraps,
    output logic       err,
    output logic [1:0] err_code,
    output logic [3:0] err_prev,
    output logic [3:0] err_cur
);

    // Bit 0 of the phase is "a sample has been taken" and bit 1 is "halted on
    // error". That makes seen and err plain flop outputs with no decode.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_HALT  = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ENCODING = 2'd1,
        ERR_JUMP     = 2'd2,
        ERR_STALL    = 2'd3
    } err_code_t;

    localparam logic [4:0] NUM_STATES = 5'(NSTATES);
    localparam logic [3:0] LAST_STATE = 4'(NSTATES - 1);
    localparam logic [8:0] STALL_MAX  = 9'(TIMEOUT);

    phase_t     phase_q, phase_d;
    logic [3:0] prev_q,  prev_d;
    logic [7:0] hold_q,  hold_d;
    logic [7:0] wraps_q, wraps_d;
    logic [1:0] code_q,  code_d;
    logic [3:0] eprev_q, eprev_d;
    logic [3:0] ecur_q,  ecur_d;

    logic [3:0] succ;
    logic       illegal;
    logic [8:0] hold_inc;
    logic       raise;
    err_code_t  raise_code;

    // Shared helper terms.
    // The successor is formed in 4 bits, so NSTATES=16 wraps naturally.
    // y is compared in 5 bits, so NSTATES=16 never flags an illegal encoding.
    assign succ     = (prev_q == LAST_STATE) ? 4'd0 : prev_q + 4'd1;
    assign illegal  = ({1'b0, y} >= NUM_STATES);
    assign hold_inc = {1'b0, hold_q} + 9'd1;

    // Next-state and datapath: classify the current enabled sample.
    always_comb begin
        // NOTE: every signal gets a default before any branch. A path that
        // leaves one unassigned would infer a latch.
        phase_d    = phase_q;
        prev_d     = prev_q;
        hold_d     = hold_q;
        wraps_d    = wraps_q;
        code_d     = code_q;
        eprev_d    = eprev_q;
        ecur_d     = ecur_q;
        raise      = 1'b0;
        raise_code = ERR_NONE;

        if (en) begin
            case (phase_q)
                ST_IDLE: begin
                    // The first sample only seeds the history. Its
                    // encoding is still checked.
                    phase_d = ST_TRACK;
                    prev_d  = y;
                    hold_d  = 8'd0;
                    if (illegal) begin
                        raise      = 1'b1;
                        raise_code = ERR_ENCODING;
                    end
                end
                ST_TRACK: begin
                    if (illegal) begin
                        raise      = 1'b1;
                        raise_code = ERR_ENCODING;
                    end else if (y == prev_q) begin
                        hold_d = hold_inc[7:0];
                        if (hold_inc >= STALL_MAX) begin
                            raise      = 1'b1;
                            raise_code = ERR_STALL;
                        end
                    end else if (y == succ) begin
                        prev_d = y;
                        hold_d = 8'd0;
                        if (prev_q == LAST_STATE && y == 4'd0 && wraps_q != 8'hFF) begin
                            wraps_d = wraps_q + 8'd1;
                        end
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_JUMP;
                    end
                end
                default: begin
                    // Halted: everything is held until reset.
                end
            endcase

            if (raise) begin
                phase_d = ST_HALT;
                code_d  = raise_code;
                eprev_d = prev_q;
                ecur_d  = y;
            end
        end
    end

    // State register with asynchronous clear of all history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= ST_IDLE;
            prev_q  <= 4'd0;
            hold_q  <= 8'd0;
            wraps_q <= 8'd0;
            code_q  <= ERR_NONE;
            eprev_q <= 4'd0;
            ecur_q  <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the values
            // from before the edge, no matter what order the statements run.
            phase_q <= phase_d;
            prev_q  <= prev_d;
            hold_q  <= hold_d;
            wraps_q <= wraps_d;
            code_q  <= code_d;
            eprev_q <= eprev_d;
            ecur_q  <= ecur_d;
        end
    end

    assign seen     = phase_q[0];
    assign err      = phase_q[1];
    assign wraps    = wraps_q;
    assign err_code = code_q;
    assign err_prev = eprev_q;
    assign err_cur  = ecur_q;

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Self-checking bench for fsm_trace_checker.
// A sample-level reference model predicts every output. A negedge process
// compares the DUT against the model on every cycle. Directed traces pin the
// model with hand-computed literal values. Randomized episodes follow them.
module tb_fsm_trace_checker;

    localparam int NS = 9;
    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] y;
    logic       seen;
    logic [7:0] wraps;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] err_prev;
    logic [3:0] err_cur;

    fsm_trace_checker #(.NSTATES(NS), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .y        (y),
        .seen     (seen),
        .wraps    (wraps),
        .err      (err),
        .err_code (err_code),
        .err_prev (err_prev),
        .err_cur  (err_cur)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, kept at the level of the sample rules.
    logic       m_seen  = 1'b0;
    logic       m_err   = 1'b0;
    int         m_prev  = 0;
    int         m_hold  = 0;
    int         m_wraps = 0;
    logic [1:0] m_code  = 2'd0;
    logic [3:0] m_eprev = 4'd0;
    logic [3:0] m_ecur  = 4'd0;

    logic [31:0] dut_vec;
    assign dut_vec = {12'd0, seen, wraps, err, err_code, err_prev, err_cur};

    function automatic logic [31:0] model_vec();
        return {12'd0, m_seen, 8'(m_wraps), m_err, m_code, m_eprev, m_ecur};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        m_seen  = 1'b0;
        m_err   = 1'b0;
        m_prev  = 0;
        m_hold  = 0;
        m_wraps = 0;
        m_code  = 2'd0;
        m_eprev = 4'd0;
        m_ecur  = 4'd0;
    endtask

    task automatic model_raise(input int code, input int v);
        m_err   = 1'b1;
        m_code  = 2'(code);
        m_eprev = 4'(m_prev);
        m_ecur  = 4'(v);
    endtask

    // Apply one rising-edge sample to the model.
    task automatic model_sample(input logic e, input int v);
        if (!e || m_err) return;
        if (!m_seen) begin
            m_seen = 1'b1;
            if (v >= NS) model_raise(1, v);
            m_prev = v;
            m_hold = 0;
        end else if (v >= NS) begin
            model_raise(1, v);
        end else if (v == m_prev) begin
            m_hold++;
            if (m_hold >= TO) model_raise(3, v);
        end else if (v == (m_prev + 1) % NS) begin
            if (v == 0 && m_wraps < 255) m_wraps++;
            m_prev = v;
            m_hold = 0;
        end else begin
            model_raise(2, v);
        end
    endtask

    // Drive one cycle, update the model at the edge, and return 1 ns later.
    task automatic step(input logic e, input int v);
        en = e;
        y  = 4'(v);
        @(posedge clock);
        model_sample(e, v);
        #1;
    endtask

    // Reset pulse placed between clock edges. The outputs must clear at once.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("reset_async", dut_vec, 32'd0);
        #1;
        reset = 1'b0;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) check("cycle", dut_vec, model_vec());

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        y     = 4'd0;
        repeat (2) @(negedge clock);
        check("reset_state", dut_vec, 32'd0);
        reset = 1'b0;

        // Legal stream of 19 samples, with two laps completed.
        for (int i = 0; i < 19; i++) step(1'b1, i % NS);
        check("legal_wraps", {31'd0, err}, 32'd0);
        check("legal_wraps_val", 32'(wraps), 32'd2);
        check("legal_seen", 32'(seen), 32'd1);

        // Illegal jump 2->5. Later samples must not change anything.
        pulse_reset();
        step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 5);
        check("jump_err", {28'd0, err, err_code, 1'b0}, {28'd0, 1'b1, 2'd2, 1'b0});
        check("jump_ctx", {24'd0, err_prev, err_cur}, {24'd0, 4'd2, 4'd5});
        step(1'b1, 14); step(1'b1, 6);
        check("jump_frozen", {22'd0, err_code, err_prev, err_cur}, {22'd0, 2'd2, 4'd2, 4'd5});

        // Illegal encoding mid-trace, then as the first sample.
        pulse_reset();
        step(1'b1, 0); step(1'b1, 1); step(1'b1, 12);
        check("enc_ctx", {22'd0, err_code, err_prev, err_cur}, {22'd0, 2'd1, 4'd1, 4'd12});
        pulse_reset();
        step(1'b1, 10);
        check("enc_first", {29'd0, seen, err_code}, {29'd0, 1'b1, 2'd1});

        // Stall: y=3 on 17 enabled samples trips on the 16th repeat.
        pulse_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 3);
        check("stall_not_yet", 32'(err), 32'd0);
        step(1'b1, 3);
        check("stall_ctx", {22'd0, err_code, err_prev, err_cur}, {22'd0, 2'd3, 4'd3, 4'd3});

        // A 40-cycle gap with en low must leave the history untouched.
        pulse_reset();
        step(1'b1, 0); step(1'b1, 1);
        for (int i = 0; i < 40; i++) step(1'b0, 7);
        step(1'b1, 2);
        check("gap_no_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 15; i++) step(1'b1, 2);
        check("gap_hold_clean", {31'd0, err}, 32'd0);

        // Reach three laps, force an error, then reset between edges.
        pulse_reset();
        for (int i = 0; i < 28; i++) step(1'b1, i % NS);
        step(1'b1, 5);
        check("mid_state", {23'd0, wraps, err}, {23'd0, 8'd3, 1'b1});
        pulse_reset();
        step(1'b1, 4);
        check("after_reset_first", {30'd0, seen, err}, {30'd0, 1'b1, 1'b0});

        // The lap counter saturates at 255.
        pulse_reset();
        for (int i = 0; i < 9 * 258 + 1; i++) step(1'b1, i % NS);
        check("wraps_saturate", 32'(wraps), 32'd255);

        // Randomized episodes, each biased toward legal progress.
        for (int ep = 0; ep < 120; ep++) begin
            pulse_reset();
            for (int k = 0; k < 40; k++) begin
                int  kind;
                int  v;
                logic e;
                e    = ($urandom_range(99) < 85);
                kind = $urandom_range(99);
                if (kind < 70)      v = (m_prev + 1) % NS;
                else if (kind < 92) v = m_prev;
                else                v = $urandom_range(15);
                step(e, v);
            end
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_trace_checker.md
FSM_TRACE_CHECKER -- requirements
Module: fsm_trace_checker

Interface
REQ-001 Parameter NSTATES, default 9: number of legal state encodings (0..NSTATES-1) on y.
REQ-002 Parameter TIMEOUT, default 16: max consecutive enabled samples of one unchanged state before a stall error.
REQ-003 The block SHALL provide the following ports; it has one clock, and reset is asynchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 en  input  1  sample qualifier; same signal that enables the 9-state fsm.
REQ-007 y  input  4  observed state index from the fsm.
REQ-008 seen  output  1  high once the first enabled sample after reset is captured.
REQ-009 wraps  output  8  count of (NSTATES-1)->0 transitions, saturating at 255.
REQ-010 err  output  1  sticky error flag.
REQ-011 err_code  output  2  first error cause: 0 none, 1 illegal encoding, 2 illegal jump, 3 stall timeout.
REQ-012 err_prev  output  4  previous legal state at first error.
REQ-013 err_cur  output  4  y value at first error.

Function
REQ-014 The block SHALL keep internal regs prev[3:0] and hold[7:0], updated only on rising edges with en=1.
REQ-015 With en=0, no register (prev, hold, wraps, seen, err*) SHALL change.
REQ-016 First enabled sample after reset: prev<=y, hold<=0, seen<=1, and no check is performed, except that y>=NSTATES SHALL raise code 1.
REQ-017 Later enabled samples SHALL be classified in priority order: y>=NSTATES -> code 1; y==prev -> hold; y==(prev+1) mod NSTATES -> advance; otherwise -> code 2.
REQ-018 Hold: hold<=hold+1. When hold+1 reaches TIMEOUT, the block SHALL raise code 3, i.e. on the TIMEOUT-th consecutive repeat sample.
REQ-019 Advance: prev<=y, hold<=0. If prev==NSTATES-1 and y==0, wraps<=wraps+1, saturating at 255 with no roll-over.
REQ-020 Raising an error SHALL set err=1 on that edge and latch err_code, err_prev=prev and err_cur=y.
REQ-021 Only the first error SHALL be latched; later errors SHALL NOT overwrite err_code, err_prev or err_cur.
REQ-022 Once err=1, the block SHALL freeze prev, hold and wraps until reset (checking halts).
REQ-023 Outputs SHALL be registered; err and err_code are visible the cycle after the offending edge sample.
REQ-024 Width rule: the mod-NSTATES successor is computed in 4 bits; NSTATES SHALL be in 2..16.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force seen=0, wraps=0, err=0, err_code=0, err_prev=0, err_cur=0, prev=0, hold=0.
REQ-026 Reset asserted mid-trace SHALL discard all history; the next enabled sample after release is treated as a first sample (REQ-016).
REQ-027 Deassertion SHALL be synchronous to clock in the surrounding test harness; no sample is taken on the release edge if en=0.

Verification
REQ-028 Legal stream: en=1, y=0,1,...,8,0,1,...,8,0 for 19 cycles -> wraps=2, err=0, seen=1.
REQ-029 Illegal jump: y=0,1,2,5 -> err=1, err_code=2, err_prev=2, err_cur=5; further y has no effect.
REQ-030 Illegal encoding: y=0,1,12 -> err_code=1, err_prev=1, err_cur=12; y=10 as first sample -> err_code=1.
REQ-031 Stall: y=3 held for 17 enabled cycles with TIMEOUT=16 -> err_code=3 after the 16th repeat, err_prev=3, err_cur=3.
REQ-032 en gating: y=0,1, then en=0 for 40 cycles with y=7, then en=1, y=2 -> err=0, and hold/prev are unchanged across the gap.
REQ-033 Reset mid-operation: after wraps=3 and err=1, pulse reset asynchronously between edges -> all outputs 0 immediately; the next sample y=4 is accepted as first, with no error.
